elastic_alu_pipeline: RTL and testbench

Parametrised, flow-controlled successor to the fixed add/sub pipeline. Each transaction computes `res = (op1 OP_A op2) OP_B op1` through a chain of `LAT` register stages with valid/ready handshakes at both ends. Optional result flags are carried alongside the data. Back-pressure and bubble collapsing allow it to sit between producers and consumers that stall.

---
 rtl/elastic_alu_pkg.sv | 31 +++
 rtl/elastic_alu_slice.sv | 57 +++++
 rtl/elastic_alu_pipeline.sv | 108 ++++++++++
 tb/tb_elastic_alu_pipeline.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/elastic_alu_pkg.sv
// elastic_alu_pkg: shared ALU opcode enum, ALU helper function and pipeline
// depth limits for the elastic add/sub/logic pipeline.
package elastic_alu_pkg;

  localparam int MIN_LAT = 3;
  localparam int MAX_DW  = 64;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alu_op_e;

  // Evaluated at full width; callers truncate to their own DWIDTH, which
  // gives modulo-2^DWIDTH arithmetic for ADD/SUB and exact AND/OR.
  function automatic logic [MAX_DW-1:0] alu_f(input alu_op_e op,
                                              input logic [MAX_DW-1:0] a,
                                              input logic [MAX_DW-1:0] b);
    logic [MAX_DW-1:0] r;
    case (op)
      ALU_ADD: r = a + b;
      ALU_SUB: r = a - b;
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/elastic_alu_slice.sv
// elastic_alu_slice: one valid + payload register stage of the elastic
// pipeline. The stage loads when it is empty or when its downstream stage
// is loading; payload only updates when the incoming valid is set.
module elastic_alu_slice
  import elastic_alu_pkg::*;
#(
  parameter int PW = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid_i,
  input  logic [PW-1:0] in_data_i,
  input  logic          en_next_i,
  output logic          en_o,
  output logic          valid_o,
  output logic [PW-1:0] data_o
);

  logic          v_q;
  logic          v_d;
  logic [PW-1:0] data_q;
  logic [PW-1:0] data_d;

  // Empty stages always load, collapsing bubbles under downstream stall.
  assign en_o    = !v_q || en_next_i;
  assign valid_o = v_q;
  assign data_o  = data_q;

  // Next-state: advance valid on enable, capture payload only for real data.
  always_comb begin
    v_d    = v_q;
    data_d = data_q;
    if (en_o) begin
      v_d = in_valid_i;
      if (in_valid_i) begin
        data_d = in_data_i;
      end else begin
        data_d = data_q;
      end
    end else begin
      v_d    = v_q;
      data_d = data_q;
    end
  end

  // Stage registers, cleared asynchronously by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q    <= 1'b0;
      data_q <= '0;
    end else begin
      v_q    <= v_d;
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/elastic_alu_pipeline.sv
// elastic_alu_pipeline: res = (op1 OPA op2) OPB op1 through LAT elastic
// register stages with valid/ready flow control at both ends.
// Optional feature macro: ELASTIC_ALU_FLAGS_EN builds zero/negative result
// flags that travel with the data; otherwise zero_o/neg_o are tied low.
module elastic_alu_pipeline
  import elastic_alu_pkg::*;
#(
  parameter int DWIDTH = 8,
  parameter int LAT    = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [DWIDTH-1:0] op1_i,
  input  logic [DWIDTH-1:0] op2_i,
  input  logic [1:0]        opa_i,
  input  logic [1:0]        opb_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DWIDTH-1:0] res_o,
  output logic              zero_o,
  output logic              neg_o
);

  localparam int S0W = 2*DWIDTH + 4;   // {opb, opa, op2, op1}
  localparam int S1W = 2*DWIDTH + 2;   // {opb, op1, rA}
`ifdef ELASTIC_ALU_FLAGS_EN
  localparam int TW  = DWIDTH + 2;     // {neg, zero, rB}
`else
  localparam int TW  = DWIDTH;         // rB
`endif

  if (LAT < MIN_LAT) begin : g_lat_chk
    $error("elastic_alu_pipeline: LAT must be at least %0d", MIN_LAT);
  end

  logic [LAT:0]        en_s;
  logic [LAT-1:0]      v_s;
  logic [S0W-1:0]      s0_in_s;
  logic [S0W-1:0]      s0_q_s;
  logic [S1W-1:0]      s1_in_s;
  logic [S1W-1:0]      s1_q_s;
  logic [DWIDTH-1:0]   ra_s;
  logic [DWIDTH-1:0]   rb_s;
  logic [TW-1:0]       s2_in_s;
  logic [TW-1:0]       tail_s [2:LAT-1];

  assign en_s[LAT] = ready_i;
  assign ready_o   = en_s[0] && !rst;
  assign valid_o   = v_s[LAT-1];

  // Stage 0 captures the raw operands and opcodes.
  assign s0_in_s = {opb_i, opa_i, op2_i, op1_i};

  elastic_alu_slice #(.PW(S0W)) u_s0 (
    .clk(clk), .rst(rst),
    .in_valid_i(valid_i), .in_data_i(s0_in_s), .en_next_i(en_s[1]),
    .en_o(en_s[0]), .valid_o(v_s[0]), .data_o(s0_q_s)
  );

  // Stage 1 computes rA = op1 OPA op2 and forwards op1/opb.
  assign ra_s = DWIDTH'(alu_f(alu_op_e'(s0_q_s[2*DWIDTH +: 2]),
                              MAX_DW'(s0_q_s[0 +: DWIDTH]),
                              MAX_DW'(s0_q_s[DWIDTH +: DWIDTH])));
  assign s1_in_s = {s0_q_s[2*DWIDTH+2 +: 2], s0_q_s[0 +: DWIDTH], ra_s};

  elastic_alu_slice #(.PW(S1W)) u_s1 (
    .clk(clk), .rst(rst),
    .in_valid_i(v_s[0]), .in_data_i(s1_in_s), .en_next_i(en_s[2]),
    .en_o(en_s[1]), .valid_o(v_s[1]), .data_o(s1_q_s)
  );

  // Stage 2 computes rB = rA OPB op1 (and the flags when enabled).
  assign rb_s = DWIDTH'(alu_f(alu_op_e'(s1_q_s[2*DWIDTH +: 2]),
                              MAX_DW'(s1_q_s[0 +: DWIDTH]),
                              MAX_DW'(s1_q_s[DWIDTH +: DWIDTH])));
`ifdef ELASTIC_ALU_FLAGS_EN
  assign s2_in_s = {rb_s[DWIDTH-1], (rb_s == '0), rb_s};
`else
  assign s2_in_s = rb_s;
`endif

  elastic_alu_slice #(.PW(TW)) u_s2 (
    .clk(clk), .rst(rst),
    .in_valid_i(v_s[1]), .in_data_i(s2_in_s), .en_next_i(en_s[3]),
    .en_o(en_s[2]), .valid_o(v_s[2]), .data_o(tail_s[2])
  );

  // Stages 3..LAT-1 are pure delay slices carrying rB (and flags).
  for (genvar k = 3; k < LAT; k++) begin : g_delay
    elastic_alu_slice #(.PW(TW)) u_sd (
      .clk(clk), .rst(rst),
      .in_valid_i(v_s[k-1]), .in_data_i(tail_s[k-1]), .en_next_i(en_s[k+1]),
      .en_o(en_s[k]), .valid_o(v_s[k]), .data_o(tail_s[k])
    );
  end

  assign res_o  = tail_s[LAT-1][DWIDTH-1:0];
`ifdef ELASTIC_ALU_FLAGS_EN
  assign zero_o = tail_s[LAT-1][DWIDTH];
  assign neg_o  = tail_s[LAT-1][DWIDTH+1];
`else
  assign zero_o = 1'b0;
  assign neg_o  = 1'b0;
`endif

endmodule

// File: tb/tb_elastic_alu_pipeline.sv
// tb_elastic_alu_pipeline: table-driven and scoreboard-based bench for
// elastic_alu_pipeline (DWIDTH=8, LAT=3). Flag expectations follow the
// ELASTIC_ALU_FLAGS_EN build setting.
module tb_elastic_alu_pipeline;

  localparam int DW = 8;
  localparam int LT = 3;

  typedef struct {
    logic [7:0] op1;
    logic [7:0] op2;
    logic [1:0] opa;
    logic [1:0] opb;
    logic [7:0] res;
    logic       zero;
    logic       neg;
  } vec_t;

  typedef struct {
    logic [7:0] res;
    logic       zero;
    logic       neg;
  } exp_t;

  logic          clk;
  logic          rst;
  logic          valid_i;
  logic          ready_o;
  logic [DW-1:0] op1_i;
  logic [DW-1:0] op2_i;
  logic [1:0]    opa_i;
  logic [1:0]    opb_i;
  logic          valid_o;
  logic          ready_i;
  logic [DW-1:0] res_o;
  logic          zero_o;
  logic          neg_o;

  int   total;
  int   bad;
  int   out_cnt;
  logic in_fire;
  logic out_fire;
  logic rdy_seen;
  exp_t cur_exp;
  exp_t sb [$];
  vec_t tbl [8];

  elastic_alu_pipeline #(.DWIDTH(DW), .LAT(LT)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o),
    .op1_i(op1_i), .op2_i(op2_i), .opa_i(opa_i), .opb_i(opb_i),
    .valid_o(valid_o), .ready_i(ready_i), .res_o(res_o),
    .zero_o(zero_o), .neg_o(neg_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] m_alu(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a & b;
      default: return a | b;
    endcase
  endfunction

  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b,
                                 input logic [1:0] oa, input logic [1:0] ob);
    exp_t e;
    e.res = m_alu(ob, m_alu(oa, a, b), a);
`ifdef ELASTIC_ALU_FLAGS_EN
    e.zero = (e.res == 8'd0);
    e.neg  = e.res[7];
`else
    e.zero = 1'b0;
    e.neg  = 1'b0;
`endif
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] b,
                       input logic [1:0] oa, input logic [1:0] ob);
    op1_i = a; op2_i = b; opa_i = oa; opb_i = ob;
    cur_exp = model(a, b, oa, ob);
  endtask

  // One clock cycle: called at the falling edge with inputs already driven.
  task automatic step();
    exp_t e;
    #1;
    rdy_seen = ready_o;
    in_fire  = valid_i && ready_o;
    out_fire = valid_o && ready_i;
    if (out_fire) begin
      out_cnt++;
      if (sb.size() == 0) begin
        chk("unexpected_output", 32'(res_o), 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        chk("res", 32'(res_o), 32'(e.res));
        chk("zero", 32'(zero_o), 32'(e.zero));
        chk("neg", 32'(neg_o), 32'(e.neg));
      end
    end
    @(posedge clk);
    if (in_fire) sb.push_back(cur_exp);
    @(negedge clk);
  endtask

  task automatic drain();
    valid_i = 1'b0;
    ready_i = 1'b1;
    for (int n = 0; n < 20 && sb.size() != 0; n++) step();
    chk("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int   lat;
    int   accepted;
    int   first_block;
    int   tp_cnt;
    logic hold;
    exp_t e;

    total = 0; bad = 0; out_cnt = 0;
    tbl[0] = '{8'd5,   8'd3,   2'd0, 2'd1, 8'd3,   1'b0, 1'b0};
    tbl[1] = '{8'd200, 8'd100, 2'd0, 2'd1, 8'd100, 1'b0, 1'b0};
    tbl[2] = '{8'd1,   8'd1,   2'd1, 2'd1, 8'hFF,  1'b0, 1'b1};
    tbl[3] = '{8'h09,  8'hF0,  2'd2, 2'd2, 8'h00,  1'b1, 1'b0};
    tbl[4] = '{8'hAA,  8'h0F,  2'd3, 2'd2, 8'hAA,  1'b0, 1'b1};
    tbl[5] = '{8'h80,  8'h80,  2'd0, 2'd3, 8'h80,  1'b0, 1'b1};
    tbl[6] = '{8'd7,   8'd2,   2'd1, 2'd0, 8'd12,  1'b0, 1'b0};
    tbl[7] = '{8'hFF,  8'h01,  2'd0, 2'd0, 8'hFF,  1'b0, 1'b1};

    rst = 1'b1; valid_i = 1'b0; ready_i = 1'b0;
    op1_i = '0; op2_i = '0; opa_i = '0; opb_i = '0;
    @(negedge clk);
    #1;
    chk("rst_valid_o", 32'(valid_o), 32'd0);
    chk("rst_res_o", 32'(res_o), 32'd0);
    chk("rst_ready_o", 32'(ready_o), 32'd0);
    chk("rst_flags", {30'd0, zero_o, neg_o}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("ready_after_rst", 32'(ready_o), 32'd1);

    // Table vectors: one at a time, checking value and exact latency.
    ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      valid_i = 1'b1;
      drive(tbl[i].op1, tbl[i].op2, tbl[i].opa, tbl[i].opb);
      cur_exp.res = tbl[i].res;
`ifdef ELASTIC_ALU_FLAGS_EN
      cur_exp.zero = tbl[i].zero;
      cur_exp.neg  = tbl[i].neg;
`endif
      step();
      chk("tbl_accept", 32'(in_fire), 32'd1);
      valid_i = 1'b0;
      lat = 0;
      for (int n = 1; n <= 20; n++) begin
        step();
        if (out_fire) begin
          lat = n;
          break;
        end
      end
      chk("tbl_latency", 32'(lat), 32'(LT));
    end
    drain();

    // Back-pressure: 5 transactions, consumer stalled for 6 cycles.
    accepted = 0; first_block = -1; out_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      ready_i = (i >= 6);
      valid_i = (accepted < 5);
      drive(8'(accepted + 1), 8'd10, 2'd0, 2'd1);
      step();
      if (!rdy_seen && first_block < 0) first_block = accepted;
      if (in_fire) accepted++;
      if (accepted == 5 && sb.size() == 0) break;
    end
    chk("bp_full_at", 32'(first_block), 32'd3);
    chk("bp_accepted", 32'(accepted), 32'd5);
    chk("bp_outputs", 32'(out_cnt), 32'd5);
    drain();

    // Bubbles and random stalls on both sides.
    hold = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (!hold) drive(8'($urandom), 8'($urandom), 2'($urandom), 2'($urandom));
      valid_i = (i < 30) ? ((i % 2) == 0) : 1'($urandom);
      ready_i = (i < 30) ? ((i % 4) < 2) : 1'($urandom);
      step();
      hold = valid_i && !in_fire;
    end
    drain();

    // Steady state: one result per cycle with both sides open.
    valid_i = 1'b1; ready_i = 1'b1; tp_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      drive(8'($urandom), 8'($urandom), 2'($urandom), 2'($urandom));
      step();
      if (i >= 10 && out_fire && in_fire) tp_cnt++;
    end
    chk("throughput", 32'(tp_cnt), 32'd10);
    drain();

    // Reset with two transactions in flight.
    ready_i = 1'b0;
    valid_i = 1'b1;
    drive(8'd5, 8'd3, 2'd0, 2'd1);
    step();
    drive(8'd9, 8'd1, 2'd0, 2'd0);
    step();
    valid_i = 1'b0;
    step();
    #2;
    chk("pre_rst_valid", 32'(valid_o), 32'd1);
    chk("pre_rst_res", 32'(res_o), 32'd3);
    rst = 1'b1;
    #1;
    chk("midrst_valid_o", 32'(valid_o), 32'd0);
    chk("midrst_res_o", 32'(res_o), 32'd0);
    chk("midrst_ready_o", 32'(ready_o), 32'd0);
    chk("midrst_flags", {30'd0, zero_o, neg_o}, 32'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    ready_i = 1'b1;
    out_cnt = 0;
    for (int i = 0; i < 10; i++) step();
    chk("no_stale_output", 32'(out_cnt), 32'd0);

    // Pipeline still works after the mid-operation reset.
    valid_i = 1'b1;
    drive(8'd200, 8'd100, 2'd0, 2'd1);
    step();
    e = cur_exp;
    chk("post_rst_model", 32'(e.res), 32'd100);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
